// File: rtl/prbs31_seq_ctrl.sv
// Command-driven PRBS31 byte sequencer; the LFSR step itself lives in an external datapath (prbs_cur -> prbs_nxt).
// Optional PRBS31_ERRINJ_EN: inj_err flips dout bit 0. Note rst_n is an active-high asynchronous reset.
module prbs31_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        cmd_err,
  output logic [31:0] prbs_cur,
  input  logic [31:0] prbs_nxt,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        seed_err,
  input  logic        inj_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_LEN   = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  state_t      state;
  logic [31:0] seed;
  logic [7:0]  len;
  logic [7:0]  cnt;
  logic        xfer;
  logic        stop_cmd;
  logic        last_xfer;

  assign cmd_ready = 1'b1;
  assign xfer      = dout_valid && dout_ready;
  assign stop_cmd  = cmd_valid && (cmd_op == OP_STOP);
  // len==0 is free-run, so only a nonzero length can end a run by itself
  assign last_xfer = xfer && (len != 8'd0) && (cnt == len - 8'd1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      seed       <= 32'd0;
      len        <= 8'd0;
      cnt        <= 8'd0;
      prbs_cur   <= 32'd0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      seed_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: seed <= {seed[23:0], cmd_data};
              OP_LEN:  len  <= cmd_data;
              OP_START: begin
                if (seed != 32'd0) begin
                  prbs_cur   <= seed;
                  cnt        <= 8'd0;
                  state      <= RUN;
                  dout_valid <= 1'b1;
                  busy       <= 1'b1;
                end else begin
                  seed_err <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (xfer) begin
            prbs_cur <= prbs_nxt;
            cnt      <= cnt + 8'd1;
          end
          if (cmd_valid && !stop_cmd) begin
            cmd_err <= 1'b1;
          end
          // STOP wins over a coincident final transfer and suppresses done
          if (stop_cmd || last_xfer) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= !stop_cmd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRBS31_ERRINJ_EN
  assign dout = prbs_cur[7:0] ^ {7'b0, inj_err};
`else
  logic unused_inj;
  assign unused_inj = inj_err;
  assign dout       = prbs_cur[7:0];
`endif

endmodule

// File: tb/tb_prbs31_seq_ctrl.sv
// Directed bench for prbs31_seq_ctrl with a stand-in step datapath and a queue of expected PRBS states.
// Honours PRBS31_ERRINJ_EN for the error-injection byte.
module tb_prbs31_seq_ctrl;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_LEN   = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

`ifdef PRBS31_ERRINJ_EN
  localparam logic [7:0] INJ_BYTE = 8'h13;
`else
  localparam logic [7:0] INJ_BYTE = 8'h12;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready;
  logic        cmd_err;
  logic [31:0] prbs_cur;
  logic [31:0] prbs_nxt;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        seed_err;
  logic        inj_err = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  got[$];

  prbs31_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .prbs_cur(prbs_cur), .prbs_nxt(prbs_nxt),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .done(done), .seed_err(seed_err), .inj_err(inj_err)
  );

  always #5 clk = ~clk;

  // Stand-in step function; chosen so that state 1 steps to a state whose low byte is 0x12
  function automatic logic [31:0] step(input logic [31:0] s);
    return ((s << 4) ^ (s << 1) ^ (s >> 27)) & 32'h7FFF_FFFF;
  endfunction

  function automatic logic [31:0] step_n(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  assign prbs_nxt = step(prbs_cur);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_states(input logic [31:0] s0, input int n);
    logic [31:0] s;
    s = s0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(s);
      s = step(s);
    end
  endtask

  // One negedge observation: any transfer about to happen is scored against the queue
  task automatic sample();
    logic [31:0] e;
    if (dout_valid && dout_ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL extra_byte: observed %h expected none", dout);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_dout", dout, e[7:0]);
        checkOutput("sb_prbs_cur", prbs_cur, e);
        got.push_back(dout);
      end
    end
    if (done) done_seen++;
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] head;
    #1 rst_n = 1'b1;
    #1;
    checkOutput("rst_dout_valid", dout_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_prbs_cur", prbs_cur, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cmd_err", cmd_err, 0);
    checkOutput("rst_seed_err", seed_err, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);

    // START with zero seed
    applyStimulus(OP_START, 8'h00);
    checkOutput("zseed_seed_err", seed_err, 1);
    checkOutput("zseed_valid", dout_valid, 0);
    checkOutput("zseed_busy", busy, 0);
    @(negedge clk);
    checkOutput("zseed_once", seed_err, 0);
    checkOutput("zseed_valid_later", dout_valid, 0);
    checkOutput("zseed_prbs_cur", prbs_cur, 0);
    applyStimulus(OP_STOP, 8'h00);
    checkOutput("stop_idle_cmd_err", cmd_err, 0);

    // Seed 1, length 3
    applyStimulus(OP_LOAD, 8'h00);
    applyStimulus(OP_LOAD, 8'h00);
    applyStimulus(OP_LOAD, 8'h00);
    applyStimulus(OP_LOAD, 8'h01);
    applyStimulus(OP_LEN, 8'd3);
    push_states(32'h1, 3);
    got.delete();
    done_seen = 0;
    dout_ready = 1'b1;
    applyStimulus(OP_START, 8'h00);
    checkOutput("start_valid", dout_valid, 1);
    checkOutput("start_busy", busy, 1);
    consume(5);
    checkOutput("len3_byte0", got[0], 8'h01);
    checkOutput("len3_byte1", got[1], 8'h12);
    checkOutput("len3_count", got.size(), 3);
    checkOutput("len3_done_once", done_seen, 1);
    checkOutput("len3_busy_low", busy, 0);
    checkOutput("len3_valid_low", dout_valid, 0);

    // Same seed and length reused; inject on the second byte
    applyStimulus(OP_START, 8'h00);
    checkOutput("inj_byte0", dout, 8'h01);
    @(negedge clk);
    inj_err = 1'b1;
    #1;
    checkOutput("inj_byte1", dout, INJ_BYTE);
    checkOutput("inj_prbs_cur", prbs_cur, 32'h12);
    inj_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("persist_done", done, 1);
    checkOutput("persist_busy", busy, 0);

    // Backpressure mid-run, with a SET_LEN rejected while running
    applyStimulus(OP_LEN, 8'd8);
    push_states(32'h1, 8);
    done_seen = 0;
    applyStimulus(OP_START, 8'h00);
    consume(2);
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      head = exp_q[0];
      checkOutput("stall_dout", dout, head[7:0]);
      checkOutput("stall_prbs_cur", prbs_cur, head);
      checkOutput("stall_valid", dout_valid, 1);
      if (i == 3) checkOutput("run_len_cmd_err", cmd_err, 1);
      if (i == 2) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_LEN;
        cmd_data  = 8'd2;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    dout_ready = 1'b1;
    consume(8);
    checkOutput("stall_done_once", done_seen, 1);
    checkOutput("stall_queue_empty", exp_q.size(), 0);
    checkOutput("stall_busy_low", busy, 0);

    // Free-run, STOP after 10 transfers; LOAD and START while running are rejected
    applyStimulus(OP_LOAD, 8'hA5);
    applyStimulus(OP_LOAD, 8'h5A);
    applyStimulus(OP_LOAD, 8'hC3);
    applyStimulus(OP_LOAD, 8'h3C);
    applyStimulus(OP_LEN, 8'd0);
    push_states(32'hA55AC33C, 10);
    done_seen = 0;
    applyStimulus(OP_START, 8'h00);
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 4) checkOutput("run_load_cmd_err", cmd_err, 1);
      if (i == 7) checkOutput("run_start_cmd_err", cmd_err, 1);
      if (i == 3) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'hFF;
      end else if (i == 6) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        cmd_data  = 8'h00;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
    applyStimulus(OP_STOP, 8'h00);
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_valid", dout_valid, 0);
    checkOutput("stop_done", done, 0);
    checkOutput("stop_cmd_err", cmd_err, 0);
    checkOutput("stop_prbs_cur", prbs_cur, step_n(32'hA55AC33C, 10));
    checkOutput("free_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    if (done) done_seen++;
    checkOutput("free_no_done", done_seen, 0);
    applyStimulus(OP_START, 8'h00);
    checkOutput("seed_kept", prbs_cur, 32'hA55AC33C);
    checkOutput("seed_kept_busy", busy, 1);

    // Asynchronous reset in the middle of a run
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("arst_valid", dout_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_prbs_cur", prbs_cur, 0);
    checkOutput("arst_dout", dout, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_cmd_err", cmd_err, 0);
    checkOutput("arst_seed_err", seed_err, 0);
    checkOutput("arst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    checkOutput("arst_no_done", done_seen, 0);
    applyStimulus(OP_START, 8'h00);
    checkOutput("arst_seed_cleared", seed_err, 1);
    checkOutput("arst_idle_valid", dout_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prbs31_seq_ctrl.md
PRBS31_SEQ_CTRL -- requirements
Module: prbs31_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high; clock clk.
REQ-003 SHALL have port cmd_valid, input, 1 bit: command strobe.
REQ-004 SHALL have port cmd_op, input, 2 bits: 00 LOAD_SEED_BYTE, 01 SET_LEN, 10 START, 11 STOP.
REQ-005 SHALL have port cmd_data, input, 8 bits: command operand.
REQ-006 SHALL have port cmd_ready, output, 1 bit: tied high; every cmd_valid cycle is accepted.
REQ-007 SHALL have port cmd_err, output, 1 bit: one-cycle pulse flagging a rejected command.
REQ-008 SHALL have port prbs_cur, output, 32 bits: current PRBS31 state driven to the external step datapath.
REQ-009 SHALL have port prbs_nxt, input, 32 bits: combinational next state returned by the datapath.
REQ-010 SHALL have port dout, output, 8 bits: output byte, equal to prbs_cur[7:0].
REQ-011 SHALL have port dout_valid, output, 1 bit: output byte valid.
REQ-012 SHALL have port dout_ready, input, 1 bit: consumer accepts the byte.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on natural completion.
REQ-015 SHALL have port seed_err, output, 1 bit: one-cycle pulse when START is issued with a zero seed.
REQ-016 SHALL have port inj_err, input, 1 bit: error-injection request (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE and RUN; there is no other state.
REQ-018 LOAD_SEED_BYTE in IDLE SHALL update seed <= {seed[23:0], cmd_data}, 1-cycle latency.
REQ-019 SET_LEN in IDLE SHALL update len <= cmd_data; len=0 means free-run until STOP, otherwise exactly len bytes are emitted.
REQ-020 START in IDLE with seed!=0 SHALL load prbs_cur<=seed, clear cnt, enter RUN, and assert dout_valid on the next cycle.
REQ-021 START in IDLE with seed==0 SHALL pulse seed_err, remain in IDLE, and leave prbs_cur unchanged.
REQ-022 In RUN, dout_valid SHALL be 1; a transfer occurs when dout_valid && dout_ready.
REQ-023 On each transfer, the block SHALL update prbs_cur<=prbs_nxt and cnt<=cnt+1 (8-bit, wraps 255->0 in free-run).
REQ-024 While dout_valid && !dout_ready, dout and prbs_cur SHALL be held stable.
REQ-025 A transfer with len!=0 and cnt==len-1 SHALL return the FSM to IDLE next cycle and pulse done.
REQ-026 STOP in RUN SHALL return the FSM to IDLE next cycle with no done pulse; it takes priority over a coincident final transfer, though that transfer still advances prbs_cur and cnt.
REQ-027 LOAD_SEED_BYTE, SET_LEN or START in RUN SHALL be ignored and SHALL pulse cmd_err.
REQ-028 STOP in IDLE SHALL be a no-op with no cmd_err.
REQ-029 seed and len SHALL persist across runs.

Reset
REQ-030 While rst_n=1, the block SHALL asynchronously force state=IDLE, seed=0, len=0, cnt=0, prbs_cur=0, dout_valid=0, busy=0, done=0, cmd_err=0, seed_err=0.
REQ-031 Reset asserted in RUN SHALL abort the run immediately; no done pulse SHALL follow.
REQ-032 cmd_ready SHALL be 1 whenever rst_n=0.

Configuration
REQ-033 With PRBS31_ERRINJ_EN defined, dout SHALL equal prbs_cur[7:0] ^ {7'b0, inj_err}, affecting only cycles where inj_err=1.
REQ-034 Without PRBS31_ERRINJ_EN, inj_err SHALL be ignored and dout SHALL equal prbs_cur[7:0].

Verification
REQ-035 Bench SHALL cover: load bytes 00,00,00,01; SET_LEN 3; START; dout_ready=1 -> dout 0x01, 0x12, next byte of the step function; done pulses once; busy drops.
REQ-036 Bench SHALL cover: START with seed=0 -> seed_err pulses once, dout_valid stays 0, FSM stays in IDLE.
REQ-037 Bench SHALL cover: run with dout_ready held low 5 cycles -> dout and prbs_cur stable, cnt unchanged; resume -> sequence continues without skipping.
REQ-038 Bench SHALL cover: len=0 run, STOP after 10 transfers -> IDLE, no done; LOAD_SEED_BYTE during the run -> cmd_err and seed unchanged.
REQ-039 Bench SHALL cover: rst_n=1 mid-run -> all outputs reach reset values without a clock edge.
REQ-040 Bench SHALL cover: with PRBS31_ERRINJ_EN, inj_err=1 on the 2nd byte -> 0x13 instead of 0x12; without the macro -> 0x12.
